// File: rtl/cnn_layer3_fc_classifier.sv
`default_nettype none
// ============================================================================
// Module  : cnn_layer3_fc_classifier
// Brief   : Captures the pooled 8x4x4 feature map, then runs a 10-class FC
//           dot product with bias, saturation and argmax.
// Revision: 1.0 - initial release
// ============================================================================
module cnn_layer3_fc_classifier #(
  parameter int DW         = 24,
  parameter int FRAC_W     = 8,
  parameter int N_CH       = 8,
  parameter int PIX_PER_CH = 16,
  parameter int N_CLASS    = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DIN_VALID,
  input  logic [DW-1:0] DIN,
  input  logic          DIN_LAST_PIX,
  input  logic [2:0]    PHASE,
  input  logic          FC_W_WEN,
  input  logic          FC_W_REN,
  input  logic [10:0]   FC_W_ADDR,
  input  logic [DW-1:0] FC_W_WDATA,
  output logic [DW-1:0] FC_W_RDATA,
  input  logic          FC_B_WEN,
  input  logic          FC_B_REN,
  input  logic [3:0]    FC_B_ADDR,
  input  logic [DW-1:0] FC_B_WDATA,
  output logic [DW-1:0] FC_B_RDATA,
  output logic          BUSY,
  output logic          RES_VALID,
  output logic [3:0]    RES_IDX,
  output logic [DW-1:0] RES_DATA,
  output logic          DONE,
  output logic [3:0]    CLASS_OUT,
  output logic          OVERRUN
);

  localparam int c_FEAT_N  = N_CH * PIX_PER_CH;
  localparam int c_W_DEPTH = N_CLASS * c_FEAT_N;
  localparam int c_FIDX_W  = $clog2(c_FEAT_N);
  localparam int c_PIX_W   = $clog2(PIX_PER_CH);
  localparam int c_CNT_W   = $clog2(c_FEAT_N + 5);
  localparam int c_AW      = 2 * DW;

  localparam logic [10:0]        c_W_DEPTH_A = 11'(c_W_DEPTH);
  localparam logic [10:0]        c_FEAT_N_A  = 11'(c_FEAT_N);
  localparam logic [3:0]         c_B_DEPTH_A = 4'(N_CLASS);
  localparam logic [3:0]         c_CLS_LAST  = 4'(N_CLASS - 1);
  localparam logic [2:0]         c_PH_LAST   = 3'(N_CH - 1);
  localparam logic [c_PIX_W-1:0] c_PIX_LAST  = c_PIX_W'(PIX_PER_CH - 1);
  // Per-class schedule: issue 0..N-1, product N+1 at latest, acc done N+2,
  // bias added at N+2, saturate at N+3, result visible at N+4.
  localparam logic [c_CNT_W-1:0] c_CNT_ISSUE = c_CNT_W'(c_FEAT_N);
  localparam logic [c_CNT_W-1:0] c_CNT_ACCE  = c_CNT_W'(c_FEAT_N + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_BIAS  = c_CNT_W'(c_FEAT_N + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT   = c_CNT_W'(c_FEAT_N + 3);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_FEAT_N + 4);
  localparam logic signed [c_AW-1:0] c_SMAX = {{(DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [c_AW-1:0] c_SMIN = {{(DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_w_mem    [c_W_DEPTH];
  logic [DW-1:0] r_b_mem    [N_CLASS];
  logic [DW-1:0] r_feat_mem [c_FEAT_N];

  logic                  r_w_wen;
  logic [10:0]           r_w_waddr;
  logic                  r_b_wen;
  logic [3:0]            r_b_waddr;
  logic [c_PIX_W-1:0]    r_pix_cnt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [3:0]            r_class;
  logic signed [DW-1:0]  r_feat_rd;
  logic signed [DW-1:0]  r_w_rd;
  logic signed [c_AW-1:0] r_prod;
  logic signed [c_AW-1:0] r_acc;
  logic signed [c_AW-1:0] r_sum;
  logic signed [DW-1:0]  r_best;
  logic [3:0]            r_best_idx;

  logic                   w_feat_we;
  logic                   w_class_end;
  logic                   w_mac_done;
  logic [c_FIDX_W-1:0]    w_fwr_idx;
  logic [c_FIDX_W-1:0]    w_idx;
  logic [10:0]            w_mac_waddr;
  logic signed [c_AW-1:0] w_mul;
  logic signed [c_AW-1:0] w_bias_ext;
  logic signed [DW-1:0]   w_sat;

  assign BUSY        = (r_state == ST_MAC);
  assign w_fwr_idx   = c_FIDX_W'(c_FIDX_W'(PHASE) * c_FIDX_W'(PIX_PER_CH) + c_FIDX_W'(r_pix_cnt));
  assign w_idx       = r_cnt[c_FIDX_W-1:0];
  assign w_mac_waddr = 11'(r_class) * c_FEAT_N_A + 11'(w_idx);
  assign w_mul       = c_AW'(r_feat_rd) * c_AW'(r_w_rd);
  assign w_bias_ext  = c_AW'(signed'(r_b_mem[r_class]));

  always_comb begin
    w_sat = r_sum[DW-1:0];
    if (r_sum > c_SMAX) begin
      w_sat = {1'b0, {(DW - 1){1'b1}}};
    end else if (r_sum < c_SMIN) begin
      w_sat = {1'b1, {(DW - 1){1'b0}}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_feat_we   = 1'b0;
    w_class_end = 1'b0;
    w_mac_done  = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (DIN_VALID) begin
          w_feat_we = 1'b1;
          if (DIN_LAST_PIX && (PHASE == c_PH_LAST)) begin
            w_state_nxt = ST_MAC;
          end
        end
      end
      ST_MAC: begin
        if (r_cnt == c_CNT_LAST) begin
          w_class_end = 1'b1;
          if (r_class == c_CLS_LAST) begin
            w_mac_done  = 1'b1;
            w_state_nxt = ST_FILL;
          end
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Host port: enable/address staged one cycle so data can follow a cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_w_wen    <= 1'b0;
      r_w_waddr  <= '0;
      r_b_wen    <= 1'b0;
      r_b_waddr  <= '0;
      FC_W_RDATA <= '0;
      FC_B_RDATA <= '0;
    end else begin
      r_w_wen   <= FC_W_WEN;
      r_w_waddr <= FC_W_ADDR;
      r_b_wen   <= FC_B_WEN;
      r_b_waddr <= FC_B_ADDR;
      if (FC_W_REN) begin
        FC_W_RDATA <= (FC_W_ADDR < c_W_DEPTH_A) ? r_w_mem[FC_W_ADDR] : '0;
      end
      if (FC_B_REN) begin
        FC_B_RDATA <= (FC_B_ADDR < c_B_DEPTH_A) ? r_b_mem[FC_B_ADDR] : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (r_w_wen && (r_w_waddr < c_W_DEPTH_A)) begin
      r_w_mem[r_w_waddr] <= FC_W_WDATA;
    end
    if (r_b_wen && (r_b_waddr < c_B_DEPTH_A)) begin
      r_b_mem[r_b_waddr] <= FC_B_WDATA;
    end
    if (w_feat_we && !RST) begin
      r_feat_mem[w_fwr_idx] <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pix_cnt  <= '0;
      r_cnt      <= '0;
      r_class    <= '0;
      r_feat_rd  <= '0;
      r_w_rd     <= '0;
      r_prod     <= '0;
      r_acc      <= '0;
      r_sum      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      RES_VALID  <= 1'b0;
      RES_IDX    <= '0;
      RES_DATA   <= '0;
      DONE       <= 1'b0;
      CLASS_OUT  <= '0;
      OVERRUN    <= 1'b0;
    end else begin
      RES_VALID <= 1'b0;
      DONE      <= 1'b0;
      if (w_feat_we) begin
        if (DIN_LAST_PIX || (r_pix_cnt == c_PIX_LAST)) begin
          r_pix_cnt <= '0;
        end else begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end
      if (r_state == ST_FILL) begin
        r_cnt   <= '0;
        r_class <= '0;
      end else begin
        if (DIN_VALID) begin
          OVERRUN <= 1'b1;
        end
        if (w_class_end) begin
          r_cnt <= '0;
          if (!w_mac_done) begin
            r_class <= r_class + 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_cnt < c_CNT_ISSUE) begin
          r_feat_rd <= r_feat_mem[w_idx];
          r_w_rd    <= r_w_mem[w_mac_waddr];
        end
        if ((r_cnt != '0) && (r_cnt <= c_CNT_ISSUE)) begin
          r_prod <= w_mul >>> FRAC_W;
        end
        if (r_cnt == '0) begin
          r_acc <= '0;
        end else if ((r_cnt >= c_CNT_W'(2)) && (r_cnt <= c_CNT_ACCE)) begin
          r_acc <= r_acc + r_prod;
        end
        if (r_cnt == c_CNT_BIAS) begin
          r_sum <= r_acc + w_bias_ext;
        end
        if (r_cnt == c_CNT_SAT) begin
          RES_VALID <= 1'b1;
          RES_IDX   <= r_class;
          RES_DATA  <= w_sat;
          // Strict compare keeps the lowest index on ties.
          if ((r_class == '0) || (w_sat > r_best)) begin
            r_best     <= w_sat;
            r_best_idx <= r_class;
          end
        end
        if (w_mac_done) begin
          DONE      <= 1'b1;
          CLASS_OUT <= r_best_idx;
          r_pix_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cnn_layer3_fc_classifier.md
Name: cnn_layer3_fc_classifier

Overview:
Fully-connected classifier stage directly downstream of the layer-2 conv/pooling block. It captures the pooled 4x4 feature map of each of the 8 output channels (PHASE 0..7) into a 128-entry feature buffer. Once the last channel completes, it computes N_CLASS signed fixed-point dot products against host-loaded weights plus bias, then reports each class score and the argmax class.

Parameters:
DW, 24, data width; signed two's complement, same format as upstream OUT.
FRAC_W, 8, fractional bits of features and weights; each product is arithmetically shifted right by FRAC_W.
N_CH, 8, number of upstream channels (phases) per image.
PIX_PER_CH, 16, pooled pixels per channel (4x4).
N_CLASS, 10, number of output classes.

Ports:
CLK  in  1  clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
DIN_VALID  in  1  upstream pooled pixel valid (upstream VALID).
DIN  in  DW  upstream pooled pixel (upstream OUT, already ReLU'd).
DIN_LAST_PIX  in  1  last pixel of current channel; qualified by DIN_VALID.
PHASE  in  3  channel index of the incoming stream; same value as upstream PHASE_SEL.
FC_W_WEN  in  1  weight write enable.
FC_W_REN  in  1  weight read enable.
FC_W_ADDR  in  11  weight address, class*N_CH*PIX_PER_CH + feature index.
FC_W_WDATA  in  DW  weight write data.
FC_W_RDATA  out  DW  weight read data, registered.
FC_B_WEN  in  1  bias write enable.
FC_B_REN  in  1  bias read enable.
FC_B_ADDR  in  4  bias address (class index).
FC_B_WDATA  in  DW  bias write data.
FC_B_RDATA  out  DW  bias read data, registered.
BUSY  out  1  high while in the MAC state.
RES_VALID  out  1  one-cycle pulse; RES_IDX and RES_DATA are valid.
RES_IDX  out  4  class index of RES_DATA.
RES_DATA  out  DW  saturated class score.
DONE  out  1  one-cycle pulse after the final class.
CLASS_OUT  out  4  argmax class; updated with DONE and held until the next DONE.
OVERRUN  out  1  sticky flag; set when DIN_VALID arrives while BUSY.

Behaviour:
- Reset values: all outputs 0; state FILL; feature pixel counter 0. Weight, bias and feature memory contents are not reset.
- Host write path: WEN and ADDR are registered one cycle. Memory commits the WDATA present in the cycle after WEN/ADDR (cycle N+1).
- Host read path: RDATA is updated one cycle after REN with mem[ADDR] and held when REN=0.
- Host access is allowed in any state. A write during BUSY gives an undefined score for the current image only.
- FILL state:
  - On each DIN_VALID, write DIN to feat[PHASE*PIX_PER_CH + pix_cnt], then increment pix_cnt.
  - DIN_LAST_PIX clears pix_cnt; it also clears if pix_cnt reaches PIX_PER_CH-1 and wraps.
  - DIN_VALID & DIN_LAST_PIX & PHASE==N_CH-1 moves to MAC in the next cycle. That last pixel is stored.
- MAC state (BUSY=1), per class k:
  - Issue feature index i=0..127, one per cycle.
  - Pipeline: cycle 1 registered read of feat[i] and w[k*128+i]; cycle 2 registered signed product (2*DW bits) >>> FRAC_W; cycle 3 accumulate into a 2*DW-bit signed accumulator, cleared at class start.
  - After the drain, add the sign-extended bias and saturate to DW bits: max 0x7FFFFF, min 0x800000 for DW=24.
  - RES_VALID pulses exactly 132 cycles (PIX_PER_CH*N_CH + 4) after class start. Class 0 starts the cycle MAC is entered.
  - The next class starts the cycle after RES_VALID, so class k RES_VALID is at cycle 132*(k+1)+k relative to MAC entry.
- Argmax: signed compare on saturated scores. A strictly greater score replaces the running best, so ties keep the lowest index.
- DONE pulses the cycle after class N_CLASS-1 RES_VALID, with CLASS_OUT updated in the same cycle. BUSY then drops and the state returns to FILL with pix_cnt=0.
- DIN_VALID during BUSY: data is dropped, feature buffer untouched, OVERRUN set. OVERRUN clears only on RST.
- RST mid-MAC: aborts immediately; no RES_VALID or DONE; back in FILL next cycle; CLASS_OUT returns to 0.

Test Plan:
- Load weights class k = k*256 (k.0) for all 128 entries, biases 0; stream 8 channels x 16 pixels of 256 (1.0) -> RES_DATA for class k = 32768*k, i.e. class 9 = 294912; CLASS_OUT=9; DONE at cycle 1330 after MAC entry.
- All weights 0x7FFFFF, all features 0x7FFFFF, bias 0 -> every RES_DATA = 0x7FFFFF (saturated); all classes tie, so CLASS_OUT=0.
- Weights -256 for all classes, features 256, bias[3]=0x010000 others 0 -> scores -32768 except class 3 = 32768; CLASS_OUT=3.
- Write weight addr 5 = 0x123456 (WDATA presented the cycle after WEN), then REN addr 5 -> FC_W_RDATA=0x123456 one cycle after REN; same check via the bias port at addr 9.
- Assert DIN_VALID for 3 cycles while BUSY -> OVERRUN=1 and held; scores identical to a run without the extra pixels.
- Assert RST at cycle 200 of MAC -> no further RES_VALID; BUSY=0; CLASS_OUT=0; a subsequent full image completes normally with the correct argmax.
